// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, IF/ID handshake
// and the redirect inputs coming back from decode.
interface instr_fetch_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] imem_addr;
  logic [PC_W-1:0] imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_instr;
  logic [PC_W-1:0] out_pc_plus4;
  logic            branch_en;
  logic [15:0]     branch_imm;
  logic            jump_en;
  logic [25:0]     jump_idx;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc_plus4,
    input  branch_en,
    input  branch_imm,
    input  jump_en,
    input  jump_idx
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc_plus4,
    output branch_en,
    output branch_imm,
    output jump_en,
    output jump_idx
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, IF/ID slot with valid/ready, decode redirects.
// Optional IF_PERF_CNT_EN adds fetch/flush performance counters.
module instr_fetch #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_flush_cnt
`endif
);

  typedef struct packed {
    logic [PC_W-1:0] instr;
    logic [PC_W-1:0] pc_plus4;
  } if_id_t;

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] target;
  if_id_t          slot;
  logic            valid;
  logic            redirect;
  logic            fire;

  assign pc_inc   = pc + PC_W'(4);
  assign br_off   = {{14{bus.branch_imm[15]}}, bus.branch_imm, 2'b00};
  assign redirect = valid & (bus.jump_en | bus.branch_en);
  assign fire     = ~valid | bus.out_ready;

  // Jump wins over branch; both are relative to the slot's pc+4.
  always_comb begin
    target = slot.pc_plus4 + br_off;
    if (bus.jump_en)
      target = {slot.pc_plus4[PC_W-1:PC_W-4], bus.jump_idx, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      valid <= 1'b0;
      slot  <= '0;
    end else if (redirect) begin
      pc    <= target;
      valid <= 1'b0;
    end else if (fire) begin
      slot  <= '{instr: bus.imem_rdata, pc_plus4: pc_inc};
      valid <= 1'b1;
      pc    <= pc_inc;
    end
  end

  assign bus.imem_addr    = pc;
  assign bus.out_valid    = valid;
  assign bus.out_instr    = slot.instr;
  assign bus.out_pc_plus4 = slot.pc_plus4;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (redirect)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      else if (valid & bus.out_ready)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: program-order address stream model,
// directed redirect/wrap/reset cases followed by randomized traffic.
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.PC_W(32)) bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  instr_fetch #(.PC_W(32), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  always_comb bus.imem_rdata = rom(bus.imem_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] flush_q[$];
  logic [31:0] tgt_q[$];
  logic [31:0] np;
  int unsigned m_fetch = 0;
  int unsigned m_flush = 0;

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(np);
      np = np + 32'd4;
    end
  endtask

  // One cycle of stimulus; the model advances on the decisions made here.
  task automatic cycle(input bit rdy, input bit je, input bit be,
                       input logic [25:0] idx, input logic [15:0] imm,
                       input bit r, input bit to_wrap);
    logic [31:0] a, p4, tgt, off;
    logic [15:0] im;
    @(negedge clk);
    im = imm;
    if (to_wrap && bus.out_valid && exp_q.size() > 0) begin
      off = 32'hFFFF_FFFC - (exp_q[0] + 32'd4);
      im  = off[17:2];
    end
    rst            = r;
    bus.out_ready  = rdy;
    bus.jump_en    = je;
    bus.branch_en  = be;
    bus.jump_idx   = idx;
    bus.branch_imm = im;
    if (r) begin
      exp_q.delete();
      np      = RPC;
      m_fetch = 0;
      m_flush = 0;
    end else if (bus.out_valid && (je || be) && exp_q.size() > 0) begin
      a  = exp_q[0];
      p4 = a + 32'd4;
      if (je) tgt = {p4[31:28], idx, 2'b00};
      else    tgt = p4 + {{14{im[15]}}, im, 2'b00};
      exp_q.delete();
      flush_q.push_back(a);
      tgt_q.push_back(tgt);
      np = tgt;
      m_flush++;
    end else if (bus.out_valid && rdy) begin
      m_fetch++;
    end
    refill();
  endtask

  task automatic run(input bit rdy, input int n);
    for (int i = 0; i < n; i++) cycle(rdy, 0, 0, '0, '0, 0, 0);
  endtask

  // Monitor: observes each cycle just before the edge acts on it.
  initial begin
    bit          prev_rst = 1'b1;
    bit          pend = 1'b0;
    logic [31:0] pend_tgt = '0;
    logic [31:0] a;
    int          idle = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        check("valid_in_reset", {31'd0, bus.out_valid},
              prev_rst ? 32'd0 : {31'd0, bus.out_valid});
        pend     = 1'b0;
        idle     = 0;
        prev_rst = 1'b1;
        continue;
      end
      if (prev_rst) begin
        check("valid_after_reset", {31'd0, bus.out_valid}, 32'd0);
        check("addr_after_reset", bus.imem_addr, RPC);
      end
      prev_rst = 1'b0;
      if (pend) begin
        check("bubble_valid", {31'd0, bus.out_valid}, 32'd0);
        check("redirect_addr", bus.imem_addr, pend_tgt);
        pend = 1'b0;
      end
      if (bus.out_valid) idle = 0;
      else if (++idle > 3) begin
        check("valid_timeout", 32'd0, 32'd1);
        idle = 0;
      end
      if (bus.out_valid && (bus.jump_en || bus.branch_en)) begin
        if (flush_q.size() == 0 || tgt_q.size() == 0) begin
          check("flush_q_empty", 32'd0, 32'd1);
        end else begin
          a        = flush_q.pop_front();
          pend_tgt = tgt_q.pop_front();
          pend     = 1'b1;
          check("flushed_instr", bus.out_instr, rom(a));
          check("flushed_pc4", bus.out_pc_plus4, a + 32'd4);
        end
      end else if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("exp_q_empty", 32'd0, 32'd1);
        end else begin
          a = exp_q.pop_front();
          check("xfer_instr", bus.out_instr, rom(a));
          check("xfer_pc4", bus.out_pc_plus4, a + 32'd4);
        end
      end
    end
  end

  initial begin
    bit je, be, r;
    bus.out_ready  = 1'b1;
    bus.jump_en    = 1'b0;
    bus.branch_en  = 1'b0;
    bus.jump_idx   = '0;
    bus.branch_imm = '0;
    np = RPC;
    refill();

    cycle(1, 0, 0, '0, '0, 1, 0);
    cycle(1, 0, 0, '0, '0, 1, 0);
    run(1, 4);
    run(0, 3);
    run(1, 3);
    cycle(1, 1, 0, 26'h10, '0, 0, 0);
    run(1, 3);
    cycle(1, 0, 1, '0, 16'hFFFE, 0, 0);
    run(1, 2);
    cycle(1, 0, 1, '0, 16'h0003, 0, 0);
    run(1, 2);
    cycle(0, 1, 1, 26'h123, 16'h0040, 0, 0);
    run(1, 3);
    cycle(1, 0, 0, '0, '0, 1, 0);
    run(1, 2);
    cycle(1, 0, 1, '0, '0, 0, 1);
    run(1, 4);
    run(0, 2);
    cycle(0, 0, 0, '0, '0, 1, 0);
    run(1, 4);

    for (int i = 0; i < 600; i++) begin
      je = ($urandom_range(0, 99) < 6);
      be = ($urandom_range(0, 99) < 8);
      r  = ($urandom_range(0, 199) == 0);
      cycle($urandom_range(0, 99) < 70, je, be,
            26'($urandom), 16'($urandom), r, 0);
    end
    run(1, 3);

`ifdef IF_PERF_CNT_EN
    @(negedge clk);
    #3;
    check("perf_fetch", perf_fetch_cnt, m_fetch);
    check("perf_flush", perf_flush_cnt, m_flush);
`endif

    @(negedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
